// File: rtl/fillrect_pkg.sv
// Shared types and the fill-pattern colour function for the rectangle filler.
package fillrect_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  typedef enum logic [1:0] {M_SOLID, M_XSTRIPE, M_YSTRIPE, M_CHECK} mode_t;

  // Widest colour the pattern function supports; callers truncate to their CW.
  localparam int PAT_W = 16;

  function automatic logic [PAT_W-1:0] pattern_colour(
    input mode_t            mode,
    input logic [PAT_W-1:0] colour,
    input logic [PAT_W-1:0] x,
    input logic [PAT_W-1:0] y
  );
    case (mode)
      M_SOLID:   return colour;
      M_XSTRIPE: return colour ^ x;
      M_YSTRIPE: return colour ^ y;
      default:   return colour ^ {PAT_W{x[0] ^ y[0]}};
    endcase
  endfunction

endpackage

// File: rtl/fillrect_if.sv
// Request and VGA plot port bundle for the rectangle filler.
interface fillrect_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
);
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] colour;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic          busy;
  logic          done;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;

  modport master (
    output start, mode, colour, x0, x1, y0, y1,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, mode, colour, x0, x1, y0, y1,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/fillrect_scan.sv
// 2-D bounded counter: row-major walk of [x0..x1c] x [y0..y1c], bounds latched on load.
module fillrect_scan #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1c,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1c,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [XW-1:0] x_nxt,
  output logic [YW-1:0] y_nxt,
  output logic          last
);
  logic [XW-1:0] x0_r, x1c_r;
  logic [YW-1:0] y1c_r;

  assign last = (x == x1c_r) && (y == y1c_r);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (load) begin
      x_nxt = x0;
      y_nxt = y0;
    end else if (en && !last) begin
      if (x < x1c_r) begin
        x_nxt = x + XW'(1);
      end else begin
        x_nxt = x0_r;
        y_nxt = y + YW'(1);
      end
    end
  end

  // NOTE: state uses non-blocking assignments under an asynchronous reset so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      x0_r  <= '0;
      x1c_r <= '0;
      y1c_r <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
      if (load) begin
        x0_r  <= x0;
        x1c_r <= x1c;
        y1c_r <= y1c;
      end
    end
  end
endmodule

// File: rtl/fillrect.sv
// Rectangle filler: latches a clipped rectangle and fill mode, then plots one pixel per clock.
module fillrect
  import fillrect_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input logic       clk,
  input logic       rst,
  fillrect_if.slave bus
);
  state_t        state, state_nxt;
  mode_t         mode_r, pat_mode;
  logic [CW-1:0] colour_r, pat_base;
  logic [XW-1:0] x1c, scan_x, x_nxt;
  logic [YW-1:0] y1c, scan_y, y_nxt;
  logic          empty, load, en, last;
  logic          busy_r, done_r, plot_r;
  logic [CW-1:0] vga_colour_r;

  assign x1c   = (bus.x1 > XW'(SCREEN_W - 1)) ? XW'(SCREEN_W - 1) : bus.x1;
  assign y1c   = (bus.y1 > YW'(SCREEN_H - 1)) ? YW'(SCREEN_H - 1) : bus.y1;
  assign empty = (bus.x0 > x1c) || (bus.y0 > y1c);
  assign load  = (state == IDLE) && bus.start && !empty;
  assign en    = (state == FILL);

  // The first pixel's colour is computed from the live request, later ones from the latched copy.
  assign pat_mode = load ? mode_t'(bus.mode) : mode_r;
  assign pat_base = load ? bus.colour : colour_r;

  fillrect_scan #(.XW(XW), .YW(YW)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .en    (en),
    .x0    (bus.x0),
    .x1c   (x1c),
    .y0    (bus.y0),
    .y1c   (y1c),
    .x     (scan_x),
    .y     (scan_y),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .last  (last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = empty ? DONE : FILL;
      FILL:    if (last) state_nxt = DONE;
      DONE:    if (!bus.start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode_r       <= M_SOLID;
      colour_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      plot_r       <= 1'b0;
      vga_colour_r <= '0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt == FILL);
      done_r <= (state_nxt == DONE);
      plot_r <= (state_nxt == FILL);
      if (load) begin
        mode_r   <= mode_t'(bus.mode);
        colour_r <= bus.colour;
      end
      if (load || (en && !last))
        vga_colour_r <= CW'(pattern_colour(pat_mode, PAT_W'(pat_base),
                                           PAT_W'(x_nxt), PAT_W'(y_nxt)));
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.vga_plot   = plot_r;
  assign bus.vga_x      = scan_x;
  assign bus.vga_y      = scan_y;
  assign bus.vga_colour = vga_colour_r;
endmodule

// File: tb/tb_fillrect.sv
// Self-checking bench for fillrect: directed vector table, corner sequences and random rectangles.
module tb_fillrect;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  typedef struct {
    string name;
    int    x0, x1, y0, y1, mode, colour;
    int    count;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  pix_t exp_q[$];

  always #5 clk = ~clk;

  fillrect_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  fillrect #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .XW(XW), .YW(YW), .CW(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: every pixel of the clipped rectangle in scan order with its pattern colour.
  function automatic void build_model(input int x0, x1, y0, y1, mode, colour);
    int x1c, y1c, c, cmask;
    exp_q.delete();
    cmask = (1 << CW) - 1;
    x1c = (x1 > SCREEN_W - 1) ? SCREEN_W - 1 : x1;
    y1c = (y1 > SCREEN_H - 1) ? SCREEN_H - 1 : y1;
    for (int y = y0; y <= y1c; y++) begin
      for (int x = x0; x <= x1c; x++) begin
        case (mode)
          0:       c = colour;
          1:       c = (colour ^ x) & cmask;
          2:       c = (colour ^ y) & cmask;
          default: c = ((x % 2) != (y % 2)) ? (colour ^ cmask) : colour;
        endcase
        exp_q.push_back('{x: x, y: y, c: c});
      end
    end
  endfunction

  task automatic run_fill(input string tag, input int x0, x1, y0, y1, mode, colour,
                          input int exp_count, input bit scramble, input bit drop_start);
    int   cyc = 0, nplot = 0, last_plot = 0, done_cyc = 0, errs = 0, budget;
    bit   fin = 1'b0;
    pix_t e, last_pix;
    build_model(x0, x1, y0, y1, mode, colour);
    check({tag, " model_count"}, exp_q.size(), exp_count);
    budget = exp_q.size() + 20;
    last_pix = '{x: 0, y: 0, c: 0};
    bus.x0 = XW'(x0); bus.x1 = XW'(x1);
    bus.y0 = YW'(y0); bus.y1 = YW'(y1);
    bus.mode = 2'(mode); bus.colour = CW'(colour);
    bus.start = 1'b1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 2) begin
        bus.x0 = XW'($urandom); bus.x1 = XW'($urandom);
        bus.y0 = YW'($urandom); bus.y1 = YW'($urandom);
        bus.mode = 2'($urandom); bus.colour = CW'($urandom);
      end
      if (bus.busy !== bus.vga_plot) errs++;
      if (bus.vga_plot === 1'b1) begin
        nplot++;
        last_plot = cyc;
        if (exp_q.size() == 0) begin
          errs++;
        end else begin
          e = exp_q.pop_front();
          last_pix = e;
          if (bus.vga_x !== XW'(e.x) || bus.vga_y !== YW'(e.y) || bus.vga_colour !== CW'(e.c)) begin
            if (errs == 0)
              $display("  %s first bad pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                       tag, bus.vga_x, bus.vga_y, bus.vga_colour, e.x, e.y, e.c);
            errs++;
          end
        end
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
    end
    check({tag, " done_seen"}, int'(fin), 1);
    check({tag, " pixel_errors"}, errs, 0);
    check({tag, " plot_count"}, nplot, exp_count);
    check({tag, " no_gaps"}, last_plot, nplot);
    check({tag, " done_cycle"}, done_cyc, last_plot + 1);
    if (nplot > 0) begin
      check({tag, " hold_x"}, int'(bus.vga_x), last_pix.x);
      check({tag, " hold_y"}, int'(bus.vga_y), last_pix.y);
    end
    if (drop_start) begin
      bus.start = 1'b0;
      @(negedge clk);
      check({tag, " done_cleared"}, int'(bus.done), 0);
      check({tag, " idle_no_plot"}, int'(bus.vga_plot), 0);
    end
  endtask

  initial begin
    vec_t vecs[4];
    int   nplot, guard, bad;
    int   rx0, rx1, ry0, ry1;

    vecs[0] = '{name: "full",  x0: 0,   x1: 159, y0: 0,   y1: 119, mode: 0, colour: 3, count: 19200};
    vecs[1] = '{name: "small", x0: 10,  x1: 12,  y0: 20,  y1: 21,  mode: 1, colour: 0, count: 6};
    vecs[2] = '{name: "clip",  x0: 150, x1: 255, y0: 118, y1: 127, mode: 2, colour: 5, count: 20};
    vecs[3] = '{name: "empty", x0: 50,  x1: 40,  y0: 0,   y1: 0,   mode: 0, colour: 7, count: 0};

    rst = 1'b1;
    bus.start = 1'b0; bus.mode = '0; bus.colour = '0;
    bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
    repeat (3) @(negedge clk);
    check("reset plot", int'(bus.vga_plot), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset xyc", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_fill(vecs[i].name, vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
               vecs[i].mode, vecs[i].colour, vecs[i].count, 1'b0, 1'b1);

    // Reset in the middle of a full-screen fill.
    bus.x0 = 8'd0; bus.x1 = 8'd159; bus.y0 = 7'd0; bus.y1 = 7'd119;
    bus.mode = 2'd0; bus.colour = 3'd3; bus.start = 1'b1;
    nplot = 0; guard = 0;
    while (nplot < 100 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.vga_plot === 1'b1) nplot++;
    end
    check("midfill reached 100 plots", nplot, 100);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midfill rst plot", int'(bus.vga_plot), 0);
    check("midfill rst busy", int'(bus.busy), 0);
    check("midfill rst xyc", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.vga_plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check("post-reset quiet", bad, 0);

    // Start held high past done: no retrigger until start drops.
    run_fill("hold", 30, 33, 40, 41, 0, 6, 8, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hold done", int'(bus.done), 1);
      check("hold no plot", int'(bus.vga_plot), 0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("hold release", int'(bus.done), 0);
    run_fill("check", 5, 8, 7, 9, 3, 2, 12, 1'b0, 1'b1);

    // Random rectangles, inputs scrambled while filling.
    for (int i = 0; i < 12; i++) begin
      rx0 = $urandom_range(0, 170);
      rx1 = rx0 - 2 + $urandom_range(0, 17);
      ry0 = $urandom_range(0, 127);
      ry1 = ry0 - 2 + $urandom_range(0, 9);
      if (rx1 < 0) rx1 = 0;
      if (ry1 < 0) ry1 = 0;
      if (ry1 > 127) ry1 = 127;
      build_model(rx0, rx1, ry0, ry1, 0, 0);
      run_fill($sformatf("rand%0d", i), rx0, rx1, ry0, ry1,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               exp_q.size(), 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
